// File: rtl/paralelo_serial.sv
// Byte-to-serial lane converter: sends SYNC_COUNT COM symbols after reset, then streams
// payload bytes MSB first, filling idle slots with COM. Optional load_ack port under PS_LOAD_ACK_EN.
module paralelo_serial #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       active
`ifdef PS_LOAD_ACK_EN
  ,
  output logic       load_ack
`endif
);

  typedef enum logic {SYNC = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [2:0] LAST_COM = 3'(SYNC_COUNT - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic [2:0] com_cnt;
  logic [7:0] shreg;
  logic [7:0] symbol;
  logic       take;
  logic       sample;

  assign sample = (cnt == 3'd7);

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) state <= SYNC;
    else        state <= state_nxt;
  end

  // ACTIVE is absorbing; only reset brings the link back to SYNC
  always_comb begin
    state_nxt = state;
    if (state == SYNC && sample && com_cnt == LAST_COM) state_nxt = ACTIVE;
  end

  always_comb begin
    take   = (state == ACTIVE) && valid_in;
    symbol = take ? data_in : COM;
  end

  // Symbol MSB goes straight to data_out at the sampling edge so there is no gap
  // between consecutive symbols; the register supplies bits 6..0 afterwards.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      cnt      <= 3'd0;
      com_cnt  <= 3'd0;
      shreg    <= 8'd0;
      data_out <= 1'b0;
      active   <= 1'b0;
    end else begin
      cnt    <= cnt + 3'd1;
      active <= (state_nxt == ACTIVE);
      if (sample) begin
        shreg    <= symbol;
        data_out <= symbol[7];
        if (state == SYNC) com_cnt <= com_cnt + 3'd1;
      end else begin
        shreg    <= {shreg[6:0], 1'b0};
        data_out <= shreg[6];
      end
    end
  end

`ifdef PS_LOAD_ACK_EN
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) load_ack <= 1'b0;
    else        load_ack <= sample && take;
  end
`endif

endmodule
